// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared period counter (edge or center aligned)
// drives CHANNELS duty comparators; period, mode and duties are double-buffered.
module pwm_multi_channel #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 8,
  parameter int DEFAULT_PERIOD = 15,
  parameter int DEFAULT_DUTY   = 4,
  parameter int ADDR_W         = $clog2(CHANNELS + 2)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick,
  output logic [WIDTH-1:0]    counter
);

  typedef enum logic [1:0] {
    HALT = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEFAULT_DUTY);

  state_t                state_r, state_s;
  logic [WIDTH-1:0]      cnt_r, cnt_s;
  logic [WIDTH-1:0]      pend_period_r, pend_period_s, act_period_r, act_period_s;
  logic                  pend_mode_r, pend_mode_s, act_mode_r, act_mode_s;
  logic [WIDTH-1:0]      pend_duty_r [CHANNELS];
  logic [WIDTH-1:0]      pend_duty_s [CHANNELS];
  logic [WIDTH-1:0]      act_duty_r  [CHANNELS];
  logic [WIDTH-1:0]      act_duty_s  [CHANNELS];
  logic [CHANNELS-1:0]   pwm_r, pwm_s;
  logic                  tick_r, tick_s;
  logic                  load_s;

  // Pending registers with this cycle's write merged in, so a write on a boundary goes straight to active.
  always_comb begin
    pend_period_s = (wr_en && (wr_addr == ADDR_W'(0))) ? wr_data : pend_period_r;
    pend_mode_s   = (wr_en && (wr_addr == ADDR_W'(1))) ? wr_data[0] : pend_mode_r;
    for (int i = 0; i < CHANNELS; i++) begin
      pend_duty_s[i] = (wr_en && (wr_addr == ADDR_W'(i + 2))) ? wr_data : pend_duty_r[i];
    end
  end

  // Counter / direction next state, boundary detection and next-cycle outputs.
  always_comb begin
    state_s = state_r;
    cnt_s   = '0;
    if (!enable) begin
      state_s = HALT;
      cnt_s   = '0;
    end else begin
      case (state_r)
        UP: begin
          if (cnt_r < act_period_r) begin
            cnt_s   = cnt_r + ONE;
            state_s = UP;
          end else if (act_mode_r && (cnt_r > ONE)) begin
            cnt_s   = cnt_r - ONE;
            state_s = DOWN;
          end else begin
            cnt_s   = '0;
            state_s = UP;
          end
        end
        DOWN: begin
          cnt_s   = (cnt_r > ONE) ? (cnt_r - ONE) : '0;
          state_s = (cnt_r > ONE) ? DOWN : UP;
        end
        default: begin
          cnt_s   = '0;
          state_s = UP;
        end
      endcase
    end
    // Counter reloading 0 (or halted) is a period boundary: active takes pending.
    load_s       = !enable || (cnt_s == '0);
    tick_s       = enable && (cnt_s == '0);
    act_period_s = load_s ? pend_period_s : act_period_r;
    act_mode_s   = load_s ? pend_mode_s : act_mode_r;
    for (int i = 0; i < CHANNELS; i++) begin
      act_duty_s[i] = load_s ? pend_duty_s[i] : act_duty_r[i];
      pwm_s[i]      = enable && (cnt_s < act_duty_s[i]);
    end
  end

  // State, parameter and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= HALT;
      cnt_r         <= '0;
      pend_period_r <= DEF_P;
      act_period_r  <= DEF_P;
      pend_mode_r   <= 1'b0;
      act_mode_r    <= 1'b0;
      pwm_r         <= '0;
      tick_r        <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        pend_duty_r[i] <= DEF_D;
        act_duty_r[i]  <= DEF_D;
      end
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      pend_period_r <= pend_period_s;
      act_period_r  <= act_period_s;
      pend_mode_r   <= pend_mode_s;
      act_mode_r    <= act_mode_s;
      pwm_r         <= pwm_s;
      tick_r        <= tick_s;
      for (int i = 0; i < CHANNELS; i++) begin
        pend_duty_r[i] <= pend_duty_s[i];
        act_duty_r[i]  <= act_duty_s[i];
      end
    end
  end

  assign pwm_out     = pwm_r;
  assign period_tick = tick_r;
  assign counter     = cnt_r;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: a period-position reference model
// feeds a scoreboard queue each cycle, plus directed checks from the test plan.
module tb_pwm_multi_channel;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic [3:0] pwm_out;
  logic       period_tick;
  logic [7:0] counter;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] cnt;
    logic       tick;
    logic [3:0] pwm;
  } exp_t;
  exp_t sb[$];

  // reference model: position within the current period plus shadow registers
  logic [7:0] m_pp, m_ap;
  logic       m_pm, m_am;
  logic [7:0] m_pd [4];
  logic [7:0] m_ad [4];
  bit         m_enq;
  int         m_pos;

  int ctr_seq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};
  int ctr_pat [8] = '{1, 1, 0, 0, 0, 0, 0, 1};

  pwm_multi_channel dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pwm_out    (pwm_out),
    .period_tick(period_tick),
    .counter    (counter)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pp = 8'd15; m_ap = 8'd15; m_pm = 1'b0; m_am = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_pd[i] = 8'd4; m_ad[i] = 8'd4;
    end
    m_enq = 1'b0; m_pos = 0;
  endtask

  task automatic model_step();
    logic [7:0] np;
    logic       nm;
    logic [7:0] nd [4];
    int len, c;
    exp_t e;
    np = m_pp; nm = m_pm; nd = m_pd;
    if (wr_en) begin
      if (wr_addr == 3'd0) np = wr_data;
      else if (wr_addr == 3'd1) nm = wr_data[0];
      else if (wr_addr <= 3'd5) nd[int'(wr_addr) - 2] = wr_data;
    end
    len = m_am ? ((m_ap == 8'd0) ? 1 : 2 * int'(m_ap)) : int'(m_ap) + 1;
    if (!enable || !m_enq) begin
      m_enq = enable;
      m_pos = 0;
      m_ap = np; m_am = nm; m_ad = nd;
    end else if (m_pos + 1 >= len) begin
      m_pos = 0;
      m_ap = np; m_am = nm; m_ad = nd;
    end else begin
      m_pos++;
    end
    m_pp = np; m_pm = nm; m_pd = nd;
    c = (m_am && m_pos > int'(m_ap)) ? 2 * int'(m_ap) - m_pos : m_pos;
    e.cnt  = 8'(c);
    e.tick = m_enq && (m_pos == 0);
    for (int i = 0; i < 4; i++) e.pwm[i] = m_enq && (8'(c) < m_ad[i]);
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clock);
    model_step();
    #1;
    e = sb.pop_front();
    check("sb_cnt", 32'(counter), 32'(e.cnt));
    check("sb_tick", 32'(period_tick), 32'(e.tick));
    check("sb_pwm", 32'(pwm_out), 32'(e.pwm));
  endtask

  task automatic write(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic wait_cnt(input logic [7:0] target, input int limit);
    for (int i = 0; i < limit && counter != target; i++) cycle();
    check("wait_cnt", 32'(counter), 32'(target));
  endtask

  task automatic wait_tick(input int limit);
    for (int i = 0; i < limit; i++) begin
      cycle();
      if (period_tick) break;
    end
    check("wait_tick", 32'(period_tick), 32'd1);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_cnt", 32'(counter), 32'd0);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_tick", 32'(period_tick), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // defaults: 16-cycle period, duty 4
    for (int k = 0; k < 20; k++) begin
      cycle();
      check("def_cnt", 32'(counter), 32'(k % 16));
      check("def_pwm", 32'(pwm_out), (k % 16 < 4) ? 32'hF : 32'h0);
      check("def_tick", 32'(period_tick), 32'(k % 16 == 0));
    end

    // shadowing: ch1 write mid-period, ch0 write on a boundary edge
    wait_cnt(8'd7, 40);
    write(3'd3, 8'd10);
    for (int k = 0; k < 7; k++) begin
      check("shadow_cnt", 32'(counter), 32'(8 + k));
      check("shadow_old", 32'(pwm_out[1]), 32'd0);
      cycle();
    end
    write(3'd2, 8'd8);
    for (int k = 0; k < 16; k++) begin
      check("shadow_new_cnt", 32'(counter), 32'(k));
      check("shadow_ch0", 32'(pwm_out[0]), 32'(k < 8));
      check("shadow_ch1", 32'(pwm_out[1]), 32'(k < 10));
      cycle();
    end

    // center mode, P=4, ch0 duty 2
    write(3'd0, 8'd4);
    write(3'd1, 8'd1);
    write(3'd2, 8'd2);
    wait_tick(40);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) cycle();
      check("ctr_cnt", 32'(counter), 32'(ctr_seq[k % 8]));
      check("ctr_pwm0", 32'(pwm_out[0]), 32'(ctr_pat[k % 8]));
      check("ctr_tick", 32'(period_tick), 32'(k % 8 == 0));
    end

    // extremes: duty 0 / 255 at P=15, then P=0
    write(3'd1, 8'd0);
    write(3'd0, 8'd15);
    write(3'd2, 8'd0);
    write(3'd3, 8'd255);
    write(3'd4, 8'd8);
    write(3'd5, 8'd1);
    wait_tick(40);
    for (int k = 0; k < 16; k++) begin
      check("ext_d0", 32'(pwm_out[0]), 32'd0);
      check("ext_d255", 32'(pwm_out[1]), 32'd1);
      cycle();
    end
    write(3'd0, 8'd0);
    wait_tick(40);
    for (int k = 0; k < 8; k++) begin
      cycle();
      check("p0_cnt", 32'(counter), 32'd0);
      check("p0_tick", 32'(period_tick), 32'd1);
      check("p0_pwm", 32'(pwm_out), 32'hE);
    end

    // enable drop at counter 9, reprogram P=7 while halted
    write(3'd0, 8'd15);
    wait_cnt(8'd9, 40);
    enable = 1'b0;
    cycle();
    check("halt_cnt", 32'(counter), 32'd0);
    check("halt_pwm", 32'(pwm_out), 32'd0);
    check("halt_tick", 32'(period_tick), 32'd0);
    write(3'd0, 8'd7);
    cycle();
    cycle();
    enable = 1'b1;
    for (int k = 0; k < 24; k++) begin
      cycle();
      check("p7_cnt", 32'(counter), 32'(k % 8));
      check("p7_tick", 32'(period_tick), 32'(k % 8 == 0));
    end

    // asynchronous reset mid-period
    wait_cnt(8'd5, 40);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_cnt", 32'(counter), 32'd0);
    check("arst_pwm", 32'(pwm_out), 32'd0);
    check("arst_tick", 32'(period_tick), 32'd0);
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      check("post_cnt", 32'(counter), 32'(k % 16));
      check("post_pwm", 32'(pwm_out), (k % 16 < 4) ? 32'hF : 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
